seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 143 ++++++++++++++
 tb/tb_seg7_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Seven-segment digit capture: decodes active-low segment patterns into hex nibbles and
// assembles four accepted digits into a 16-bit word with ready/valid on both sides.
module seg7_capture #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [2:0]  digit_cnt,
    output logic        err_invalid,
    output logic        err_timeout
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e          r_state;
    logic [15:0]     r_word;
    logic [15:0]     r_word_out;
    logic            r_word_valid;
    logic [2:0]      r_digit_cnt;
    logic            r_err_inv;
    logic            r_err_tmo;
    logic [TmoW-1:0] r_tmo_cnt;

    logic [3:0]      w_nibble;
    logic            w_is_digit;
    logic            w_is_blank;
    logic            w_xfer;
    logic            w_digit_xfer;
    logic            w_inv_xfer;
    logic [TmoW-1:0] w_tmo_inc;
    logic            w_tmo_hit;

    // Patterns are active-low, bit6..bit0 = a b c d e f g.
    always_comb begin
        w_nibble   = 4'h0;
        w_is_digit = 1'b1;
        w_is_blank = 1'b0;
        case (seg_in)
            7'b0000001: w_nibble = 4'h0;
            7'b1001111: w_nibble = 4'h1;
            7'b0010010: w_nibble = 4'h2;
            7'b0000110: w_nibble = 4'h3;
            7'b1001100: w_nibble = 4'h4;
            7'b0100100: w_nibble = 4'h5;
            7'b0100000: w_nibble = 4'h6;
            7'b0001111: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0001100: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b1100000: w_nibble = 4'hB;
            7'b0110001: w_nibble = 4'hC;
            7'b1000010: w_nibble = 4'hD;
            7'b0110000: w_nibble = 4'hE;
            7'b0111000: w_nibble = 4'hF;
            7'b1111111: begin
                w_is_digit = 1'b0;
                w_is_blank = 1'b1;
            end
            default:    w_is_digit = 1'b0;
        endcase
    end

    assign seg_ready    = (r_state != StDone);
    assign w_xfer       = seg_valid & seg_ready;
    assign w_digit_xfer = w_xfer & w_is_digit;
    assign w_inv_xfer   = w_xfer & ~w_is_digit & ~w_is_blank;
    assign w_tmo_inc    = r_tmo_cnt + TmoW'(1);
    assign w_tmo_hit    = (w_tmo_inc == TmoW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_word       <= 16'h0000;
            r_word_out   <= 16'h0000;
            r_word_valid <= 1'b0;
            r_digit_cnt  <= 3'd0;
            r_err_inv    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_err_inv <= 1'b0;
            r_err_tmo <= 1'b0;
            case (r_state)
                StIdle, StCollect: begin
                    // A digit transfer outranks both an invalid pattern and the timeout.
                    if (w_digit_xfer) begin
                        r_word      <= {r_word[11:0], w_nibble};
                        r_digit_cnt <= r_digit_cnt + 3'd1;
                        r_tmo_cnt   <= '0;
                        if (r_digit_cnt == 3'd3) begin
                            r_state      <= StDone;
                            r_word_valid <= 1'b1;
                            r_word_out   <= {r_word[11:0], w_nibble};
                        end else begin
                            r_state <= StCollect;
                        end
                    end else if (w_inv_xfer) begin
                        r_err_inv   <= 1'b1;
                        r_word      <= 16'h0000;
                        r_digit_cnt <= 3'd0;
                        r_tmo_cnt   <= '0;
                        r_state     <= StIdle;
                    end else if (r_state == StCollect) begin
                        if (w_tmo_hit) begin
                            r_err_tmo   <= 1'b1;
                            r_word      <= 16'h0000;
                            r_digit_cnt <= 3'd0;
                            r_tmo_cnt   <= '0;
                            r_state     <= StIdle;
                        end else begin
                            r_tmo_cnt <= w_tmo_inc;
                        end
                    end
                end
                StDone: begin
                    if (word_ready) begin
                        r_state      <= StIdle;
                        r_word_valid <= 1'b0;
                        r_word_out   <= 16'h0000;
                        r_word       <= 16'h0000;
                        r_digit_cnt  <= 3'd0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign digit_cnt   = r_digit_cnt;
    assign err_invalid = r_err_inv;
    assign err_timeout = r_err_tmo;

endmodule

// File: tb/tb_seg7_capture.sv
// Table-driven bench for seg7_capture with a scoreboard of expected words popped on handshake.
module tb_seg7_capture;

    localparam logic [1:0] KDig = 2'd0;
    localparam logic [1:0] KBlk = 2'd1;
    localparam logic [1:0] KInv = 2'd2;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] kind;
        logic [3:0] nib;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  digit_cnt;
    logic        err_invalid;
    logic        err_timeout;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_word = 16'h0;
    int          m_cnt = 0;
    vec_t        tbl[$];
    logic [6:0]  seg_of[16];

    seg7_capture #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .digit_cnt  (digit_cnt),
        .err_invalid(err_invalid),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Words are checked when the consumer handshake is observed.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", word_out, 32'hFFFF_FFFF);
                else chk("word_out", word_out, exp_q.pop_front());
            end
            if (!word_valid) chk("word_out_idle_zero", word_out, 0);
            if (err_invalid && err_timeout) chk("both_errors", 1, 0);
        end
    end

    task automatic model_clear();
        m_word = 16'h0;
        m_cnt  = 0;
    endtask

    task automatic send(input logic [6:0] seg, input logic [1:0] kind, input logic [3:0] nib);
        int guard = 0;
        seg_in    = seg;
        seg_valid = 1'b1;
        while (!seg_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!seg_ready) begin
            chk("seg_ready_wait", 0, 1);
            seg_valid = 1'b0;
            return;
        end
        step();
        seg_valid = 1'b0;
        if (kind == KDig) begin
            m_word = {m_word[11:0], nib};
            m_cnt++;
            chk("digit_cnt", digit_cnt, m_cnt);
            chk("err_invalid_digit", err_invalid, 0);
            if (m_cnt == 4) begin
                chk("word_valid_set", word_valid, 1);
                exp_q.push_back(m_word);
                model_clear();
            end
        end else if (kind == KBlk) begin
            chk("blank_cnt", digit_cnt, m_cnt);
            chk("blank_no_err", err_invalid, 0);
        end else begin
            model_clear();
            chk("err_invalid_pulse", err_invalid, 1);
            chk("invalid_clears_cnt", digit_cnt, 0);
            step();
            chk("err_invalid_one_cycle", err_invalid, 0);
        end
    endtask

    task automatic tmo_run(input bit blanks);
        int hit = 0;
        send(seg_of[5], KDig, 4'h5);
        send(seg_of[7], KDig, 4'h7);
        seg_in    = 7'b1111111;
        seg_valid = blanks;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (err_timeout) begin
                hit = k;
                break;
            end
        end
        seg_valid = 1'b0;
        chk(blanks ? "tmo_cycle_blanks" : "tmo_cycle", hit, 8);
        chk("tmo_clears_cnt", digit_cnt, 0);
        step();
        chk("tmo_one_cycle", err_timeout, 0);
        model_clear();
    endtask

    initial begin
        seg_of = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                   7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                   7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tbl.push_back('{7'b0000001, KDig, 4'h0});
        tbl.push_back('{7'b1111111, KBlk, 4'h0});
        tbl.push_back('{7'b1111110, KInv, 4'h0});
        tbl.push_back('{7'b1010101, KInv, 4'h0});
        for (int i = 0; i < 16; i++) tbl.push_back('{seg_of[i], KDig, 4'(i)});
        tbl.push_back('{7'b1001111, KDig, 4'h1});
        tbl.push_back('{7'b1111111, KBlk, 4'h0});
        tbl.push_back('{7'b0000110, KDig, 4'h3});
        tbl.push_back('{7'b0111111, KInv, 4'h0});
        tbl.push_back('{7'b0111000, KDig, 4'hF});
        tbl.push_back('{7'b0110000, KDig, 4'hE});
        tbl.push_back('{7'b1000010, KDig, 4'hD});
        tbl.push_back('{7'b0110001, KDig, 4'hC});

        rst        = 1'b1;
        seg_in     = 7'b1111111;
        seg_valid  = 1'b0;
        word_ready = 1'b1;
        #2;
        chk("rst_word_out", word_out, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_err_invalid", err_invalid, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_seg_ready", seg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_seg_ready", seg_ready, 1);

        foreach (tbl[i]) send(tbl[i].seg, tbl[i].kind, tbl[i].nib);

        // 1 A 2 F with an always-ready consumer.
        send(7'b1001111, KDig, 4'h1);
        send(7'b0001000, KDig, 4'hA);
        send(7'b0010010, KDig, 4'h2);
        send(7'b0111000, KDig, 4'hF);
        chk("word_1a2f", word_out, 16'h1A2F);
        step();
        chk("valid_one_cycle", word_valid, 0);
        chk("back_to_idle_cnt", digit_cnt, 0);
        chk("back_to_idle_ready", seg_ready, 1);

        // Held word with back-pressure; a fifth pattern must not be taken.
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(7'b0000000, KDig, 4'h8);
        seg_in    = 7'b1001111;
        seg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", word_valid, 1);
            chk("hold_word", word_out, 16'h8888);
            chk("hold_seg_ready", seg_ready, 0);
            chk("hold_cnt", digit_cnt, 4);
            step();
        end
        seg_valid  = 1'b0;
        word_ready = 1'b1;
        step();
        chk("release_valid", word_valid, 0);
        chk("fifth_not_taken", digit_cnt, 0);

        tmo_run(1'b0);
        tmo_run(1'b1);

        // Digit on the terminal cycle wins over the timeout.
        send(seg_of[2], KDig, 4'h2);
        send(seg_of[3], KDig, 4'h3);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("no_early_tmo", err_timeout, 0);
        end
        send(seg_of[4], KDig, 4'h4);
        chk("tmo_priority", err_timeout, 0);
        send(seg_of[5], KDig, 4'h5);

        // Asynchronous reset in the middle of a partial word.
        send(seg_of[9], KDig, 4'h9);
        send(seg_of[9], KDig, 4'h9);
        send(seg_of[9], KDig, 4'h9);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_cnt", digit_cnt, 0);
        chk("async_rst_valid", word_valid, 0);
        chk("async_rst_ready", seg_ready, 1);
        chk("async_rst_errs", {err_invalid, err_timeout}, 0);
        #2;
        rst = 1'b0;
        model_clear();
        step();
        send(seg_of[12], KDig, 4'hC);
        chk("fresh_cnt", digit_cnt, 1);
        send(seg_of[0], KDig, 4'h0);
        send(seg_of[13], KDig, 4'hD);
        send(seg_of[14], KDig, 4'hE);

        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
